sync_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ram.sv | 18 +
 rtl/sync_fifo.sv | 71 +++++++
 tb/tb_sync_fifo.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers, read-mode constants and parameter legality checks for the FIFO family.
package fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic bit depth_ok(input int depth);
    return depth >= 4 && (depth & (depth - 1)) == 0;
  endfunction
  function automatic bit thresh_ok(input int depth, input int ae, input int af);
    return ae >= 0 && ae < af && af <= depth;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_WIDTH storage, synchronous write port and asynchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with optional first-word-fall-through, threshold flags,
// fill level and sticky overflow/underflow.
module sync_fifo import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int PTR_WIDTH = clog2(DEPTH),
  parameter int FWFT = FIFO_MODE_STD,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_C = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_C = (PTR_WIDTH+1)'(AE_THRESH);
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 4");
  end
  if (!thresh_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_thresh
    $error("sync_fifo: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo: FWFT must be 0 or 1");
  end
  logic [PTR_WIDTH:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] rdata, dout_q;
  logic we, re;
  assign count = wptr - rptr;
  assign full = count == DEPTH_C;
  assign empty = count == '0;
  assign almost_full = count >= AF_C;
  assign almost_empty = count <= AE_C;
  // rst gates the RAM write here because the RAM port has no reset of its own
  assign we = w_en && !full && !rst;
  assign re = r_en && !empty && !rst;
  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(PTR_WIDTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wptr[PTR_WIDTH-1:0]),
    .wdata(din),
    .raddr(rptr[PTR_WIDTH-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      dout_q <= '0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      if (w_en && full) overflow <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
      if (re) dout_q <= rdata;
    end
  assign dout = (FWFT == FIFO_MODE_FWFT) ? rdata : dout_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: table-driven check of a standard-mode FIFO plus hand-written
// sequences for sustained simultaneous traffic and FWFT mode.
module tb_sync_fifo;
  typedef struct packed {
    logic       rst, w, r;
    logic [7:0] din;
    logic [3:0] count;
    logic [7:0] dout;
    logic       full, empty, af, ae, ovf, udf;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic s_rst, s_w, s_r, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [7:0] s_din, s_dout;
  logic [3:0] s_count;
  logic f_rst, f_w, f_r, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [7:0] f_din, f_dout;
  logic [3:0] f_count;
  int n_vec = 0, n_bad = 0;
  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
    .clk(clk), .rst(s_rst), .w_en(s_w), .din(s_din), .r_en(s_r), .dout(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );
  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
    .clk(clk), .rst(f_rst), .w_en(f_w), .din(f_din), .r_en(f_r), .dout(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );
  function automatic vec_t v(input logic rst, w, r, input logic [7:0] din,
                             input logic [3:0] count, input logic [7:0] dout,
                             input logic full, empty, af, ae, ovf, udf);
    return '{rst, w, r, din, count, dout, full, empty, af, ae, ovf, udf};
  endfunction
  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask
  task automatic s_step(input logic rst, w, r, input logic [7:0] din);
    @(negedge clk);
    s_rst = rst; s_w = w; s_r = r; s_din = din;
    @(posedge clk);
    #1;
  endtask
  task automatic f_step(input logic rst, w, r, input logic [7:0] din);
    @(negedge clk);
    f_rst = rst; f_w = w; f_r = r; f_din = din;
    @(posedge clk);
    #1;
  endtask
  vec_t vecs[$];
  logic [7:0] q[$];
  logic [7:0] exp_d;
  initial begin
    s_rst = 0; s_w = 0; s_r = 0; s_din = 0;
    f_rst = 0; f_w = 0; f_r = 0; f_din = 0;
    //                rst w r din    cnt dout  full empty af ae ovf udf
    vecs.push_back(v(1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h01, 1, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h02, 2, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h03, 3, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h04, 4, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h05, 5, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h06, 6, 8'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h07, 7, 8'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h08, 8, 8'h00, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h09, 8, 8'h00, 1, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 7, 8'h01, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 6, 8'h02, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 5, 8'h03, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 4, 8'h04, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 3, 8'h05, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 2, 8'h06, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 1, 8'h07, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 0, 8'h08, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 0, 8'h08, 0, 1, 0, 1, 1, 1));
    vecs.push_back(v(1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h10, 1, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h11, 2, 8'h00, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h12, 3, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h13, 4, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h14, 5, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h15, 6, 8'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h16, 7, 8'h00, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 8'h17, 8, 8'h00, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 8'h18, 7, 8'h10, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 6, 8'h11, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 5, 8'h12, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 1, 0, 8'hEE, 0, 8'h00, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 8'h33, 1, 8'h00, 0, 0, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 1, 8'h00, 0, 8'h33, 0, 1, 0, 1, 0, 1));
    foreach (vecs[i]) begin
      s_step(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].din);
      check("count", i, 32'(s_count), 32'(vecs[i].count));
      check("dout", i, 32'(s_dout), 32'(vecs[i].dout));
      check("flags", i, {s_full, s_empty, s_af, s_ae, s_ovf, s_udf},
            {vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae, vecs[i].ovf, vecs[i].udf});
    end
    // sustained read+write at count 4; 24 writes in total wrap the 8-entry pointers
    s_step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      s_step(0, 1, 0, 8'(8'h40 + i));
      q.push_back(8'(8'h40 + i));
    end
    check("pre_both_count", 0, 32'(s_count), 32'd4);
    for (int i = 0; i < 20; i++) begin
      exp_d = q.pop_front();
      q.push_back(8'(8'h44 + i));
      s_step(0, 1, 1, 8'(8'h44 + i));
      check("both_count", i, 32'(s_count), 32'd4);
      check("both_dout", i, 32'(s_dout), 32'(exp_d));
    end
    check("both_ovf_udf", 0, {s_ovf, s_udf}, 2'b00);
    s_step(0, 0, 0, 8'h00);
    // first-word-fall-through
    f_step(1, 0, 0, 8'h00);
    check("fwft_rst_empty", 0, 32'(f_empty), 32'd1);
    f_step(0, 1, 0, 8'hA5);
    check("fwft_dout_a5", 0, 32'(f_dout), 32'hA5);
    check("fwft_empty", 0, 32'(f_empty), 32'd0);
    f_step(0, 1, 0, 8'h5A);
    check("fwft_head_hold", 0, 32'(f_dout), 32'hA5);
    check("fwft_count2", 0, 32'(f_count), 32'd2);
    f_step(0, 0, 1, 8'h00);
    check("fwft_dout_5a", 0, 32'(f_dout), 32'h5A);
    check("fwft_count1", 0, 32'(f_count), 32'd1);
    f_step(0, 0, 1, 8'h00);
    check("fwft_drained", 0, {f_empty, f_udf}, 2'b10);
    f_step(0, 0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
